// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//
// I2C target (slave) endpoint that responds to a single 7-bit address.
// SCL/SDA are oversampled on clk through a synchronizer and one edge-detect
// register, so every bus event is acted on SYNC_STAGES+1 clocks after the pin
// changes. Write bytes are handed to user logic on rx_data/rx_valid. Read
// bytes are requested with tx_req and taken from tx_data. Both pins are
// open-drain: they are driven only to 0 or released to Z.
//
// Parameters
//   TARGET_ADDR  7-bit address this target ACKs
//   SYNC_STAGES  synchronizer depth on SCL/SDA (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   sda        I2C data (inout, 0 or Z)
//   scl        I2C clock (inout, 0 or Z; driven only for clock stretching)
//   rx_data    last byte written by the master
//   rx_valid   1-cycle pulse when rx_data is updated
//   tx_data    byte returned on a read
//   tx_valid   tx_data ready (used only when stretching is built in)
//   tx_req     1-cycle pulse requesting the next read byte
//   addressed  high from address ACK until STOP, START or master NACK
//   rw         R/W bit of the current transfer (1 = read)
//   ack_rx     master ACK(0)/NACK(1) of the last read byte
//
// Build option
//   I2C_TARGET_STRETCH_EN  when defined, SCL is held low at the start of a
//                          read byte until tx_valid is seen. When undefined,
//                          scl is never driven, tx_valid is ignored and
//                          tx_data is sampled unconditionally at the SCL fall
//                          that starts each read byte.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | bus free or unknown, waiting for START
// ST_ADDR     | shifting in address byte (7-bit address + R/W)
// ST_ADDR_ACK | address matched, SDA held low for the ACK bit
// ST_WR_DATA  | shifting in a write data byte
// ST_WR_ACK   | SDA held low to ACK a write byte
// ST_RD_DATA  | shifting out a read byte on SDA
// ST_RD_ACK   | SDA released, sampling master ACK/NACK
// ST_IGNORE   | not addressed / read ended; wait for START or STOP
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    inout  wire        scl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       addressed,
    output logic       rw,
    output logic       ack_rx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [7:0]             rx_sh;
    logic [6:0]             tx_sh;     // bits still to send after the one on SDA
    logic                   sda_low;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic                   load_fall;

    // ------------------------------------------------------------------
    // Input path: synchronizer then edge-detect register. Reset to 1 so
    // an idle (pulled-up) bus produces no spurious edges after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // START/STOP need SCL high on both samples so an SCL edge coinciding
    // with an SDA edge is never mistaken for a bus condition.
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

    // SCL fall that starts a read byte: end of the address ACK on a read,
    // or end of a master ACK (a NACK leaves RD_ACK on the rising edge).
    assign load_fall = scl_fall &
                       (((state == ST_ADDR_ACK) && rw) || (state == ST_RD_ACK));

`ifdef I2C_TARGET_STRETCH_EN
    logic scl_low;
    logic tx_pend;   // holding SCL low, waiting for tx_valid
    logic scl_rel;   // byte loaded last clk, release SCL now
    assign scl = scl_low ? 1'b0 : 1'bz;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
    assign scl = 1'bz;
`endif

    assign sda = sda_low ? 1'b0 : 1'bz;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 7'h00;
            sda_low   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            ack_rx    <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_low   <= 1'b0;
            tx_pend   <= 1'b0;
            scl_rel   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;

            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= 4'd0;
                addressed <= 1'b0;
                sda_low   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                scl_low   <= 1'b0;
                tx_pend   <= 1'b0;
                scl_rel   <= 1'b0;
`endif
            end else if (stop_det) begin
                state     <= ST_IDLE;
                bit_cnt   <= 4'd0;
                addressed <= 1'b0;
                sda_low   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                scl_low   <= 1'b0;
                tx_pend   <= 1'b0;
                scl_rel   <= 1'b0;
`endif
            end else if (load_fall) begin
                state   <= ST_RD_DATA;
                bit_cnt <= 4'd0;
`ifdef I2C_TARGET_STRETCH_EN
                if (tx_valid) begin
                    sda_low <= ~tx_data[7];
                    tx_sh   <= tx_data[6:0];
                end else begin
                    sda_low <= 1'b0;
                    scl_low <= 1'b1;
                    tx_pend <= 1'b1;
                end
`else
                sda_low <= ~tx_data[7];
                tx_sh   <= tx_data[6:0];
`endif
            end else begin
`ifdef I2C_TARGET_STRETCH_EN
                // Bit 7 goes on SDA the clk tx_valid is seen; SCL is let go
                // one clk later so SDA is settled before the master's rise.
                if (scl_rel) begin
                    scl_low <= 1'b0;
                    scl_rel <= 1'b0;
                end
                if (tx_pend && tx_valid) begin
                    sda_low <= ~tx_data[7];
                    tx_sh   <= tx_data[6:0];
                    tx_pend <= 1'b0;
                    scl_rel <= 1'b1;
                end
`endif
                case (state)
                    ST_IDLE: begin
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            rx_sh <= {rx_sh[6:0], sda_s};
                            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            bit_cnt <= 4'd0;
                            if (rx_sh[7:1] == TARGET_ADDR) begin
                                state     <= ST_ADDR_ACK;
                                sda_low   <= 1'b1;
                                rw        <= rx_sh[0];
                                addressed <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        // The read-side fall is handled by load_fall.
                        if (scl_rise && rw) begin
                            tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            state   <= ST_WR_DATA;
                            sda_low <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            rx_sh <= {rx_sh[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {rx_sh[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            state   <= ST_WR_ACK;
                            sda_low <= 1'b1;
                            bit_cnt <= 4'd0;
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            state   <= ST_WR_DATA;
                            sda_low <= 1'b0;
                        end
                    end

                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_RD_ACK;
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                            end else begin
                                sda_low <= ~tx_sh[6];
                                tx_sh   <= {tx_sh[5:0], 1'b0};
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            ack_rx <= sda_s;
                            if (sda_s) begin
                                addressed <= 1'b0;
                                state     <= ST_IGNORE;
                            end else begin
                                tx_req <= 1'b1;
                            end
                        end
                    end

                    ST_IGNORE: begin
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    wire        sda;
    wire        scl;
    logic       m_sda_low;
    logic       m_scl_low;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addressed;
    logic       rw;
    logic       ack_rx;

    pullup (sda);
    pullup (scl);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sda       (sda),
        .scl       (scl),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_req    (tx_req),
        .addressed (addressed),
        .rw        (rw),
        .ack_rx    (ack_rx)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitors: log write bytes, count read requests and serve tx_data.
    logic [7:0] rx_log [0:15];
    logic [7:0] tx_q   [0:7];
    int rx_cnt   = 0;
    int txr_cnt  = 0;
    int tx_idx   = 0;
    int max_wait = 0;
    int last_wait;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (tx_req) begin
            tx_data = tx_q[tx_idx[2:0]];
            tx_idx++;
            txr_cnt++;
        end
    end

    // ---------------- master bit-level tasks ----------------
    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_up(output int waited);
        m_scl_low = 1'b0;
        waited = 0;
        @(negedge clk);
        while (scl !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (scl !== 1'b1) chk("scl_release_timeout", 32'(scl), 32'd1);
        if (waited > max_wait) max_wait = waited;
    endtask

    task automatic wr_bit(input logic b);
        m_sda_low = ~b;
        quarter();
        scl_up(last_wait);
        quarter();
        quarter();
        m_scl_low = 1'b1;
        quarter();
    endtask

    task automatic rd_bit(output logic b);
        m_sda_low = 1'b0;
        quarter();
        scl_up(last_wait);
        quarter();
        b = sda;
        quarter();
        m_scl_low = 1'b1;
        quarter();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(ack);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b1;
        quarter();
        m_scl_low = 1'b1;
        quarter();
    endtask

    task automatic i2c_rstart();
        m_sda_low = 1'b0;
        quarter();
        scl_up(last_wait);
        quarter();
        m_sda_low = 1'b1;
        quarter();
        m_scl_low = 1'b1;
        quarter();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        quarter();
        scl_up(last_wait);
        quarter();
        m_sda_low = 1'b0;
        quarter();
        quarter();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         r0;
        int         t0;

        tx_q = '{8'h96, 8'h0F, 8'h5A, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00};
        rst       = 1'b0;
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'h00;
        repeat (5) @(negedge clk);

        // reset state
        chk("rst_rx_data",   32'(rx_data),   32'h00);
        chk("rst_rx_valid",  32'(rx_valid),  32'd0);
        chk("rst_tx_req",    32'(tx_req),    32'd0);
        chk("rst_addressed", 32'(addressed), 32'd0);
        chk("rst_rw",        32'(rw),        32'd0);
        chk("rst_ack_rx",    32'(ack_rx),    32'd0);
        chk("rst_sda_free",  32'(sda),       32'd1);
        chk("rst_scl_free",  32'(scl),       32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: write two bytes then STOP
        i2c_start();
        wr_byte(8'hA0, ack);
        chk("t1_addr_ack", 32'(ack), 32'd0);
        chk("t1_addressed", 32'(addressed), 32'd1);
        chk("t1_rw", 32'(rw), 32'd0);
        wr_byte(8'hA5, ack);
        chk("t1_d0_ack", 32'(ack), 32'd0);
        wr_byte(8'h3C, ack);
        chk("t1_d1_ack", 32'(ack), 32'd0);
        chk("t1_addressed_before_stop", 32'(addressed), 32'd1);
        i2c_stop();
        chk("t1_addressed_after_stop", 32'(addressed), 32'd0);
        chk("t1_rx_count", 32'(rx_cnt), 32'd2);
        chk("t1_rx0", 32'(rx_log[0]), 32'hA5);
        chk("t1_rx1", 32'(rx_log[1]), 32'h3C);
        chk("t1_rx_data", 32'(rx_data), 32'h3C);

        // 2: read two bytes, ACK then NACK
        t0 = txr_cnt;
        i2c_start();
        wr_byte(8'hA1, ack);
        chk("t2_addr_ack", 32'(ack), 32'd0);
        chk("t2_rw", 32'(rw), 32'd1);
        rd_byte(d, 1'b0);
        chk("t2_byte0", 32'(d), 32'h96);
        chk("t2_ack_rx_ack", 32'(ack_rx), 32'd0);
        rd_byte(d, 1'b1);
        chk("t2_byte1", 32'(d), 32'h0F);
        chk("t2_tx_req_count", 32'(txr_cnt - t0), 32'd2);
        chk("t2_ack_rx_nack", 32'(ack_rx), 32'd1);
        chk("t2_addressed", 32'(addressed), 32'd0);
        i2c_stop();

        // 3: other address is ignored
        r0 = rx_cnt;
        t0 = txr_cnt;
        i2c_start();
        wr_byte(8'hA2, ack);
        chk("t3_addr_nack", 32'(ack), 32'd1);
        chk("t3_addressed", 32'(addressed), 32'd0);
        wr_byte(8'hFF, ack);
        chk("t3_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        chk("t3_no_rx", 32'(rx_cnt - r0), 32'd0);
        chk("t3_no_tx_req", 32'(txr_cnt - t0), 32'd0);

        // 4: write, repeated START, read
        i2c_start();
        wr_byte(8'hA0, ack);
        chk("t4_addr_w_ack", 32'(ack), 32'd0);
        chk("t4_rw0", 32'(rw), 32'd0);
        wr_byte(8'h11, ack);
        chk("t4_data_ack", 32'(ack), 32'd0);
        chk("t4_rx", 32'(rx_data), 32'h11);
        t0 = txr_cnt;
        i2c_rstart();
        wr_byte(8'hA1, ack);
        chk("t4_addr_r_ack", 32'(ack), 32'd0);
        chk("t4_rw1", 32'(rw), 32'd1);
        chk("t4_tx_req", 32'(txr_cnt - t0), 32'd1);
        chk("t4_addressed", 32'(addressed), 32'd1);
        rd_byte(d, 1'b1);
        chk("t4_rd_byte", 32'(d), 32'h5A);
        i2c_stop();

        // 5: reset in the middle of bit 4 of a read of 0x00
        i2c_start();
        wr_byte(8'hA1, ack);
        chk("t5_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) rd_bit(b);
        m_sda_low = 1'b0;
        quarter();
        scl_up(last_wait);
        quarter();
        chk("t5_bit4_driven_low", 32'(sda), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_sda_released", 32'(sda), 32'd1);
        chk("t5_scl_released", 32'(scl), 32'd1);
        chk("t5_addressed", 32'(addressed), 32'd0);
        chk("t5_rw", 32'(rw), 32'd0);
        chk("t5_rx_data", 32'(rx_data), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        i2c_start();
        wr_byte(8'hA0, ack);
        chk("t5_after_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'h77, ack);
        chk("t5_after_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("t5_after_rx", 32'(rx_data), 32'h77);

`ifdef I2C_TARGET_STRETCH_EN
        // 6: read with tx_valid late -> SCL stretched
        tx_idx   = 4;
        tx_valid = 1'b0;
        i2c_start();
        wr_byte(8'hA1, ack);
        chk("t6_addr_ack", 32'(ack), 32'd0);
        max_wait = 0;
        fork
            begin
                repeat (50) @(negedge clk);
                tx_valid = 1'b1;
            end
        join_none
        rd_byte(d, 1'b1);
        chk("t6_byte", 32'(d), 32'h3C);
        chk("t6_stretch_len_ok", 32'(max_wait >= 30 && max_wait <= 50), 32'd1);
        i2c_stop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
